// File: rtl/pipe_stage_arb_pkg.sv
// Shared definitions for the pipeline-stage round-robin arbiter.
// Holds the default beat width, the statistics counter width and the
// arbitration FSM state type.
package pipe_stage_arb_pkg;

    localparam int DATA_W_DEFAULT = 19;
    localparam int STAT_W         = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

endpackage

// File: rtl/pipe_stage_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Scans req starting at ptr and wrapping modulo NUM_REQ. It returns the
// first set position as a one-hot grant, and any=1 when req has a bit set.
module rr_pick
    import pipe_stage_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic               any
);

    // first requesting position at or after ptr, wrapping around
    always_comb begin
        int idx;
        gnt = '0;
        any = 1'b0;
        idx = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = (int'(ptr) + off) % NUM_REQ;
            if (!any && req[idx]) begin
                gnt[idx] = 1'b1;
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_arbiter.sv
// pipe_stage_arbiter: round-robin arbiter with bounded burst hold.
// It drives one pipeline stage input from NUM_REQ requesters. The stage
// receives a registered beat one cycle after the beat is accepted. stall
// freezes arbitration without losing holder, burst count or pointer.
// Optional per-requester accept counters: define PIPE_STAGE_ARB_STATS_EN.
module pipe_stage_arbiter
    import pipe_stage_arb_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      stall,
    output logic [DATA_W-1:0]         stage_data,
    output logic                      stage_valid,
    output logic [ID_W-1:0]           stage_src
`ifdef PIPE_STAGE_ARB_STATS_EN
    ,
    input  logic                      stat_clr,
    output logic [NUM_REQ*STAT_W-1:0] stat_cnt
`endif
);

    localparam int              CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    state_t               state_q, state_d;
    logic [ID_W-1:0]      cur_q, cur_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [NUM_REQ-1:0]   pick_gnt;
    logic                 pick_any;
    logic [ID_W-1:0]      pick_idx;
    logic [NUM_REQ-1:0]   cur_oh;
    logic                 hold;
    logic [NUM_REQ-1:0]   grant;
    logic                 accept;
    logic [ID_W-1:0]      acc_idx;
    logic [DATA_W-1:0]    beat_sel;

    logic [DATA_W-1:0]    beat_p1;
    logic                 vld_p1;
    logic [ID_W-1:0]      src_p1;

    function automatic logic [ID_W-1:0] oh2idx(input logic [NUM_REQ-1:0] oh);
        logic [ID_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) r = ID_W'(i);
        end
        return r;
    endfunction

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .any (pick_any)
    );

    // grant: keep the holder while its burst budget lasts, else re-arbitrate
    always_comb begin
        cur_oh        = '0;
        cur_oh[cur_q] = 1'b1;
        hold          = (state_q == BURST) && req_valid[cur_q] && (cnt_q < MAX_CNT);
        grant         = '0;
        if (!rst && !stall) begin
            grant = hold ? cur_oh : pick_gnt;
        end
        accept   = |grant;
        acc_idx  = oh2idx(grant);
        pick_idx = oh2idx(pick_gnt);
        beat_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) beat_sel = req_data[i*DATA_W +: DATA_W];
        end
    end

    assign req_ready = grant;

    // next state: hold frozen under stall, burst extend, or new grant from ptr
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        if (!stall) begin
            if (hold) begin
                cnt_d = cnt_q + 1'b1;
            end else if (pick_any) begin
                state_d = BURST;
                cur_d   = pick_idx;
                cnt_d   = CNT_W'(1);
                ptr_d   = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
            end else begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end
    end

    // arbitration state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q   <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    // ---- stage p1: registered beat towards the pipeline stage ----
    // output register; data and source hold on cycles without an accept
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            beat_p1 <= '0;
            src_p1  <= '0;
        end else begin
            vld_p1 <= accept;
            if (accept) begin
                beat_p1 <= beat_sel;
                src_p1  <= acc_idx;
            end
        end
    end

    assign stage_data  = beat_p1;
    assign stage_valid = vld_p1;
    assign stage_src   = src_p1;

`ifdef PIPE_STAGE_ARB_STATS_EN
    logic [STAT_W-1:0] stat_q [NUM_REQ];

    // saturating accept counters; clear wins over a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i] && (stat_q[i] != '1)) stat_q[i] <= stat_q[i] + 1'b1;
            end
        end
    end

    // flatten counters onto the output bus
    always_comb begin
        stat_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) stat_cnt[i*STAT_W +: STAT_W] = stat_q[i];
    end
`endif

endmodule

// File: tb/tb_pipe_stage_arbiter.sv
// Testbench for pipe_stage_arbiter: directed scenarios plus a randomized run
// checked against a holder/run-length reference model.
// Counter scenarios are compiled in when PIPE_STAGE_ARB_STATS_EN is defined.
module tb_pipe_stage_arbiter;
    import pipe_stage_arb_pkg::*;

    localparam int NR = 4;
    localparam int DW = 19;
    localparam int MB = 4;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              stall;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     ready, ready1;
    logic [DW-1:0]     sdata, sdata1;
    logic              svalid, svalid1;
    logic [IW-1:0]     ssrc, ssrc1;
`ifdef PIPE_STAGE_ARB_STATS_EN
    logic              stat_clr;
    logic [NR*16-1:0]  stat_cnt, stat_cnt1;
`endif

    int total = 0;
    int bad   = 0;

    // reference model: holder, length of its current run, next scan start
    int m_ptr, m_hold, m_run;

    always #5 clk = ~clk;

    pipe_stage_arbiter #(.DATA_W(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(ready), .stall(stall), .stage_data(sdata),
        .stage_valid(svalid), .stage_src(ssrc)
`ifdef PIPE_STAGE_ARB_STATS_EN
        , .stat_clr(stat_clr), .stat_cnt(stat_cnt)
`endif
    );

    pipe_stage_arbiter #(.DATA_W(DW), .NUM_REQ(NR), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(ready1), .stall(stall), .stage_data(sdata1),
        .stage_valid(svalid1), .stage_src(ssrc1)
`ifdef PIPE_STAGE_ARB_STATS_EN
        , .stat_clr(stat_clr), .stat_cnt(stat_cnt1)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall = 1'b0;
        req_valid = '0;
        tick();
        tick();
        rst = 1'b0;
        m_ptr = 0;
        m_hold = -1;
        m_run = 0;
    endtask

    function automatic int model_pick(input logic [NR-1:0] v, input logic st);
        if (st) return -1;
        if (m_hold >= 0 && v[m_hold] && m_run < MB) return m_hold;
        for (int o = 0; o < NR; o++) begin
            if (v[(m_ptr + o) % NR]) return (m_ptr + o) % NR;
        end
        return -1;
    endfunction

    task automatic model_update(input int g, input logic st);
        if (st) return;
        if (g < 0) begin
            m_hold = -1;
            m_run = 0;
        end else if (g == m_hold && m_run < MB) begin
            m_run = m_run + 1;
        end else begin
            m_hold = g;
            m_run = 1;
            m_ptr = (g + 1) % NR;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        stall = 1'b0;
        req_valid = '1;
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = DW'($urandom);
        for (int c = 0; c < 2; c++) begin
            tick();
            total++; if (ready !== '0)   begin bad++; $display("FAIL reset_ready got=%b want=0", ready); end
            total++; if (ready1 !== '0)  begin bad++; $display("FAIL reset_ready1 got=%b want=0", ready1); end
            total++; if (svalid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", svalid); end
            total++; if (sdata !== '0)   begin bad++; $display("FAIL reset_data got=%h want=0", sdata); end
            total++; if (ssrc !== '0)    begin bad++; $display("FAIL reset_src got=%0d want=0", ssrc); end
            total++; if ({svalid1, sdata1, ssrc1} !== '0) begin bad++; $display("FAIL reset_dut1 got=%b/%h/%0d want=0", svalid1, sdata1, ssrc1); end
        end
    endtask

    task automatic test_single_stream();
        do_reset();
        req_data = '0;
        for (int b = 1; b <= 6; b++) begin
            req_valid = 4'b0100;
            req_data[2*DW +: DW] = DW'(b);
            #1;
            total++; if (ready !== 4'b0100) begin bad++; $display("FAIL stream_ready beat=%0d got=%b want=0100", b, ready); end
            tick();
            total++; if (svalid !== 1'b1 || sdata !== DW'(b) || ssrc !== 2'd2)
                begin bad++; $display("FAIL stream_out beat=%0d got=%b/%h/%0d want=1/%h/2", b, svalid, sdata, ssrc, DW'(b)); end
        end
        req_valid = '0;
        tick();
        total++; if (svalid !== 1'b0 || sdata !== DW'(6) || ssrc !== 2'd2)
            begin bad++; $display("FAIL stream_idle got=%b/%h/%0d want=0/6/2", svalid, sdata, ssrc); end
    endtask

    task automatic test_round_robin();
        int exp4 [17] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0};
        int exp1 [6]  = '{0,1,2,3,0,1};
        logic [NR-1:0] e;
        do_reset();
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = DW'(16'h100 * (i + 1));
        req_valid = '1;
        for (int c = 0; c < 17; c++) begin
            #1;
            e = NR'(1 << exp4[c]);
            total++; if (ready !== e) begin bad++; $display("FAIL rr_burst4 cyc=%0d got=%b want=%b", c, ready, e); end
            if (c < 6) begin
                e = NR'(1 << exp1[c]);
                total++; if (ready1 !== e) begin bad++; $display("FAIL rr_burst1 cyc=%0d got=%b want=%b", c, ready1, e); end
            end
            tick();
            total++; if (svalid !== 1'b1 || ssrc !== IW'(exp4[c]) || sdata !== DW'(16'h100 * (exp4[c] + 1)))
                begin bad++; $display("FAIL rr_out cyc=%0d got=%b/%0d/%h want=1/%0d", c, svalid, ssrc, sdata, exp4[c]); end
        end
    endtask

    task automatic test_stall();
        logic [NR-1:0] exp_r [8] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0100};
        logic          st    [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        do_reset();
        req_valid = 4'b0110;
        for (int c = 0; c < 8; c++) begin
            stall = st[c];
            #1;
            total++; if (ready !== exp_r[c]) begin bad++; $display("FAIL stall_ready cyc=%0d got=%b want=%b", c, ready, exp_r[c]); end
            tick();
            total++; if (svalid !== (exp_r[c] != '0)) begin bad++; $display("FAIL stall_valid cyc=%0d got=%b want=%b", c, svalid, exp_r[c] != '0); end
        end
        stall = 1'b0;
    endtask

    task automatic test_rst_midburst();
        do_reset();
        req_valid = 4'b1000;
        #1;
        total++; if (ready !== 4'b1000) begin bad++; $display("FAIL midrst_pre got=%b want=1000", ready); end
        tick();
        tick();
        rst = 1'b1;
        req_valid = '1;
        #1;
        total++; if (ready !== '0) begin bad++; $display("FAIL midrst_ready got=%b want=0", ready); end
        tick();
        total++; if (svalid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", svalid); end
        rst = 1'b0;
        #1;
        total++; if (ready !== 4'b0001) begin bad++; $display("FAIL midrst_first got=%b want=0001", ready); end
        tick();
        total++; if (svalid !== 1'b1 || ssrc !== 2'd0) begin bad++; $display("FAIL midrst_out got=%b/%0d want=1/0", svalid, ssrc); end
    endtask

    task automatic test_random();
        int g;
        logic          exp_v;
        logic [DW-1:0] exp_d;
        logic [IW-1:0] exp_s;
        logic [NR-1:0] exp_r;
        do_reset();
        exp_d = '0;
        exp_s = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] && ($urandom % 3 == 0)) begin
                    req_valid[i] = 1'b1;
                    req_data[i*DW +: DW] = DW'($urandom);
                end
            end
            stall = ($urandom % 8 == 0);
            #1;
            g = model_pick(req_valid, stall);
            exp_r = (g >= 0) ? NR'(1 << g) : '0;
            total++; if (ready !== exp_r) begin bad++; $display("FAIL rand_ready cyc=%0d got=%b want=%b", c, ready, exp_r); end
            exp_v = (g >= 0);
            if (g >= 0) begin
                exp_d = req_data[g*DW +: DW];
                exp_s = IW'(g);
            end
            model_update(g, stall);
            tick();
            total++; if (svalid !== exp_v || sdata !== exp_d || ssrc !== exp_s)
                begin bad++; $display("FAIL rand_out cyc=%0d got=%b/%h/%0d want=%b/%h/%0d", c, svalid, sdata, ssrc, exp_v, exp_d, exp_s); end
            if (g >= 0) begin
                if ($urandom % 2 == 0) req_valid[g] = 1'b0;
                else req_data[g*DW +: DW] = DW'($urandom);
            end
        end
        stall = 1'b0;
        req_valid = '0;
    endtask

`ifdef PIPE_STAGE_ARB_STATS_EN
    task automatic test_stats();
        stat_clr = 1'b0;
        do_reset();
        req_valid = 4'b1000;
        repeat (5) tick();
        req_valid = '0;
        total++; if (stat_cnt[3*16 +: 16] !== 16'd5) begin bad++; $display("FAIL stat_five got=%0d want=5", stat_cnt[3*16 +: 16]); end
        total++; if (stat_cnt[0 +: 16] !== 16'd0) begin bad++; $display("FAIL stat_other got=%0d want=0", stat_cnt[0 +: 16]); end
        req_valid = 4'b1000;
        stat_clr = 1'b1;
        #1;
        total++; if (ready !== 4'b1000) begin bad++; $display("FAIL stat_clr_accept got=%b want=1000", ready); end
        tick();
        stat_clr = 1'b0;
        total++; if (stat_cnt[3*16 +: 16] !== 16'd0) begin bad++; $display("FAIL stat_clr got=%0d want=0", stat_cnt[3*16 +: 16]); end
        repeat (65535) @(posedge clk);
        #1;
        total++; if (stat_cnt[3*16 +: 16] !== 16'hFFFF) begin bad++; $display("FAIL stat_full got=%h want=ffff", stat_cnt[3*16 +: 16]); end
        tick();
        req_valid = '0;
        total++; if (stat_cnt[3*16 +: 16] !== 16'hFFFF) begin bad++; $display("FAIL stat_sat got=%h want=ffff", stat_cnt[3*16 +: 16]); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        req_valid = '0;
        req_data = '0;
`ifdef PIPE_STAGE_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        m_ptr = 0;
        m_hold = -1;
        m_run = 0;
        #1;
        test_reset();
        test_single_stream();
        test_round_robin();
        test_stall();
        test_rst_midburst();
        test_random();
`ifdef PIPE_STAGE_ARB_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
